// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and constants for the PC sequencer.
// State encoding, next-PC source select and alignment helper.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_FETCH    = 2'd1,
    ST_WAIT     = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_RESET,
    SEL_HOLD,
    SEL_INC,
    SEL_TARGET,
    SEL_PENDING
  } pc_sel_t;

  localparam int unsigned INSTR_BYTES = 4;
  localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/pc_seq_if.sv
// pc_seq_if: pipeline-side bundle of the PC sequencer.
// master drives hazard/redirect/memory status, slave returns PC control.
interface pc_seq_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      pc_out;
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump;
  logic [31:0]      jump_target;
  logic             imem_ready;
  logic [31:0]      next_pc;
  logic             imem_req;
  logic             if_id_write;
  logic             if_id_flush;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output pc_out, stall,
    output branch_taken, branch_target,
    output jump, jump_target,
    output imem_ready,
    input  next_pc, imem_req,
    input  if_id_write, if_id_flush,
    input  stall_count
  );

  modport slave (
    input  pc_out, stall,
    input  branch_taken, branch_target,
    input  jump, jump_target,
    input  imem_ready,
    output next_pc, imem_req,
    output if_id_write, if_id_flush,
    output stall_count
  );
endinterface

// File: rtl/pc_seq_fsm.sv
// pc_seq_fsm: fetch control FSM of the PC sequencer.
// Owns the state register; decodes control and next-PC source.
module pc_seq_fsm
  import pc_seq_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    imem_ready,
  input  logic    stall,
  input  logic    redirect,
  output state_t  state,
  output logic    imem_req,
  output logic    if_id_write,
  output logic    if_id_flush,
  output logic    latch_pend,
  output pc_sel_t pc_sel
);

  state_t state_nx;
  logic   boot;
  logic   redir_now;
  logic   redir_late;
  logic   drain_done;
  logic   seq_adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_BOOT;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_BOOT: state_nx = ST_FETCH;
      ST_FETCH, ST_WAIT: begin
        if (imem_ready)    state_nx = ST_FETCH;
        else if (redirect) state_nx = ST_REDIRECT;
        else               state_nx = ST_WAIT;
      end
      ST_REDIRECT: begin
        if (imem_ready) state_nx = ST_FETCH;
      end
      default: state_nx = ST_BOOT;
    endcase
  end

  // Mutually exclusive terms; anything else holds the PC.
  assign boot       = (state == ST_BOOT);
  assign redir_now  = !boot && redirect && imem_ready;
  assign redir_late = !boot && redirect && !imem_ready;
  assign drain_done = !boot && !redirect && imem_ready
                    && (state == ST_REDIRECT);
  assign seq_adv    = !boot && !redirect && imem_ready
                    && (state != ST_REDIRECT) && !stall;

  always_comb begin
    imem_req    = 1'b1;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    latch_pend  = 1'b0;
    pc_sel      = SEL_HOLD;
    unique case (1'b1)
      boot: begin
        imem_req    = 1'b0;
        if_id_flush = 1'b1;
        pc_sel      = SEL_RESET;
      end
      redir_now: begin
        if_id_flush = 1'b1;
        pc_sel      = SEL_TARGET;
      end
      redir_late: latch_pend = 1'b1;
      drain_done: begin
        if_id_flush = 1'b1;
        pc_sel      = SEL_PENDING;
      end
      seq_adv: begin
        if_id_write = 1'b1;
        pc_sel      = SEL_INC;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC selection and IF/ID control for the fetch stage.
// Holds the deferred redirect target and a saturating hold counter.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
  parameter int          CNT_W        = 16
) (
  input logic   clk,
  input logic   rst_n,
  pc_seq_if.slave bus
);

  state_t           state;
  pc_sel_t          pc_sel;
  logic             redirect;
  logic             latch_pend;
  logic             hold;
  logic [31:0]      target;
  logic [31:0]      pend_pc;
  logic [31:0]      inc_pc;
  logic [31:0]      next_pc;
  logic [CNT_W-1:0] cnt;

  // Branch wins over jump when both resolve together.
  assign redirect = bus.branch_taken | bus.jump;
  assign target   = word_align(bus.branch_taken ? bus.branch_target
                                                : bus.jump_target);
  assign inc_pc   = bus.pc_out + 32'(INSTR_BYTES);

  pc_seq_fsm u_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_ready  (bus.imem_ready),
    .stall       (bus.stall),
    .redirect    (redirect),
    .state       (state),
    .imem_req    (bus.imem_req),
    .if_id_write (bus.if_id_write),
    .if_id_flush (bus.if_id_flush),
    .latch_pend  (latch_pend),
    .pc_sel      (pc_sel)
  );

  always_comb begin
    next_pc = bus.pc_out;
    unique case (pc_sel)
      SEL_RESET:   next_pc = RESET_VECTOR;
      SEL_INC:     next_pc = inc_pc;
      SEL_TARGET:  next_pc = target;
      SEL_PENDING: next_pc = pend_pc;
      default:     next_pc = bus.pc_out;
    endcase
  end

  assign bus.next_pc = next_pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          pend_pc <= '0;
    else if (latch_pend) pend_pc <= target;
  end

  assign hold = (state != ST_BOOT) && (next_pc == bus.pc_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (hold && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

  assign bus.stall_count = cnt;

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter CNT_W, default 16, width of stall-cycle counter.
REQ-003 Clk  input  1  single clock; all state changes on rising edge.
REQ-004 Rst_n  input  1  reset, asynchronous, active-low.
REQ-005 PcOut  input  32  current PC, from PC_REGISTER Out.
REQ-006 Stall  input  1  load-use hazard; hold PC and IF/ID.
REQ-007 BranchTaken  input  1  taken branch resolved this cycle.
REQ-008 BranchTarget  input  32  branch destination.
REQ-009 Jump  input  1  jump resolved this cycle.
REQ-010 JumpTarget  input  32  jump destination.
REQ-011 ImemReady  input  1  instruction memory completes current fetch.
REQ-012 NextPc  output  32  drives PC_REGISTER In; PC_REGISTER loads it every edge.
REQ-013 ImemReq  output  1  fetch request at PcOut.
REQ-014 IfIdWrite  output  1  IF/ID register enable.
REQ-015 IfIdFlush  output  1  IF/ID register clear (insert bubble).
REQ-016 StallCount  output  CNT_W  saturating count of cycles with NextPc==PcOut while out of BOOT.

Function
REQ-017 FSM states: BOOT, FETCH, WAIT, REDIRECT; all outputs except StallCount decoded combinationally from state and inputs.
REQ-018 BOOT: NextPc=RESET_VECTOR, ImemReq=0, IfIdWrite=0, IfIdFlush=1; unconditional transition to FETCH next edge.
REQ-019 FETCH/WAIT: ImemReq=1; ImemReady=0 and no redirect -> NextPc=PcOut, IfIdWrite=0, go/stay WAIT.
REQ-020 FETCH/WAIT, ImemReady=1, no redirect, Stall=0 -> NextPc=PcOut+4 (mod 2^32, wraps FFFF_FFFC->0000_0000), IfIdWrite=1, go FETCH.
REQ-021 FETCH/WAIT, ImemReady=1, Stall=1, no redirect -> NextPc=PcOut, IfIdWrite=0, IfIdFlush=0, stay FETCH (fetch reissued).
REQ-022 Redirect = BranchTaken|Jump; BranchTaken has priority over Jump when both high; redirect overrides Stall.
REQ-023 Redirect in FETCH/WAIT with ImemReady=1 -> NextPc=selected target, IfIdFlush=1, IfIdWrite=0, go FETCH; zero-cycle redirect latency.
REQ-024 Redirect in FETCH/WAIT with ImemReady=0 -> latch target into PendingPc, NextPc=PcOut, go REDIRECT.
REQ-025 REDIRECT: ImemReq=1 (in-flight fetch drained), IfIdWrite=0; ImemReady=1 -> NextPc=PendingPc, IfIdFlush=1, go FETCH; else hold PcOut.
REQ-026 New redirect while in REDIRECT overwrites PendingPc (latest wins), with REQ-022 priority; if coincident with ImemReady=1, new target used directly.
REQ-027 Targets used with bits [1:0] forced to 00.
REQ-028 StallCount increments by 1 per qualifying cycle, saturates at all-ones, never wraps.

Reset
REQ-029 Rst_n low asynchronously forces state BOOT, PendingPc=0, StallCount=0; outputs take BOOT values immediately.
REQ-030 Reset mid-WAIT or mid-REDIRECT discards pending target; first post-reset NextPc is RESET_VECTOR.
REQ-031 Deassertion is synchronised by the system; block leaves BOOT on first rising edge with Rst_n high.

Structure
REQ-032 Shared package pc_seq_pkg holds state enum (2-bit), INSTR_BYTES=4, default RESET_VECTOR.
REQ-033 One sub-module pc_seq_fsm: state register and next-state logic; NextPc mux, PendingPc and StallCount in pc_sequencer top.
REQ-034 No combinational path from NextPc to any input; PC_REGISTER remains a separate instance.

Verification
REQ-035 Reset release, ImemReady=1 constant -> NextPc sequence 0,4,8,C; IfIdFlush=1 only in BOOT cycle.
REQ-036 PcOut=0x100, ImemReady=0 for 3 cycles -> NextPc=0x100 held, IfIdWrite=0, then 0x104 on ready.
REQ-037 PcOut=0x200, BranchTaken=1 target 0x403 and Jump=1 target 0x800, ImemReady=1 -> NextPc=0x400, IfIdFlush=1.
REQ-038 Jump target 0x900 with ImemReady=0, then Branch target 0xA00 next cycle, ready 2 cycles later -> NextPc=0xA00 on ready cycle, flush once.
REQ-039 Stall=1 for 5 cycles with ImemReady=1, then released -> PC held, StallCount=5; with CNT_W=2, 5 stall cycles give StallCount=3 (saturated).
REQ-040 PcOut=0xFFFF_FFFC sequential fetch -> NextPc=0x0000_0000; Rst_n pulsed low mid-REDIRECT -> immediate BOOT outputs, StallCount=0.
